dmem_responder: RTL and testbench

//  Responder end of the core's data-memory port (wen/ren/addr/wdata -> rdata).

---
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with RAM, console TX FIFO, status and optional cycle timer
// Timer block (CYCLE/COMPARE/timer_irq) is built only when DMEM_RESP_TIMER_EN is defined.
module dmem_responder #(
  parameter int MEM_DEPTH  = 256,
  parameter int MMIO_BASE  = 'hF0,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen,
  input  logic          ren,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          console_valid,
  output logic [7:0]    console_data,
  input  logic          console_ready,
  output logic          timer_irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] A_TX  = AW'(MMIO_BASE);
  localparam logic [AW-1:0] A_ST  = AW'(MMIO_BASE + 1);
  localparam logic [AW-1:0] A_CY  = AW'(MMIO_BASE + 2);
  localparam logic [AW-1:0] A_CMP = AW'(MMIO_BASE + 3);

  logic [31:0]   mem [MMIO_BASE];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          ram_sel, empty, full, pop, push_req, push_ok, st_wr;
  logic [31:0]   status, cyc_rd, cmp_rd;

  always_comb begin
    ram_sel  = addr < AW'(MMIO_BASE);
    empty    = cnt_q == '0;
    full     = cnt_q == CW'(FIFO_DEPTH);
    pop      = !empty && console_ready;
    push_req = wen && addr == A_TX;
    push_ok  = push_req && (!full || pop);
    st_wr    = wen && addr == A_ST;
    wr_d     = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    cnt_d    = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d    = (push_req && !push_ok) || (ovf_q && !(st_wr && wdata[2]));
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end

  // Storage arrays are not reset; the FIFO count alone defines what is live.
  always_ff @(posedge clk) begin
    if (wen && ram_sel) mem[addr] <= wdata;
    if (push_ok) fifo[wr_q] <= wdata[7:0];
  end

`ifdef DMEM_RESP_TIMER_EN
  logic [31:0] cyc_q, cyc_d, cmp_q, cmp_d;
  logic        irq_q, irq_d;

  always_comb begin
    cyc_d = (wen && addr == A_CY) ? wdata : cyc_q + 32'd1;
    cmp_d = (wen && addr == A_CMP) ? wdata : cmp_q;
    irq_d = (cyc_d == cmp_q) || (irq_q && !(st_wr && wdata[3]));
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cyc_q <= '0;
      cmp_q <= '1;
      irq_q <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      cmp_q <= cmp_d;
      irq_q <= irq_d;
    end

  assign timer_irq = irq_q;
  assign cyc_rd    = cyc_q;
  assign cmp_rd    = cmp_q;
`else
  assign timer_irq = 1'b0;
  assign cyc_rd    = '0;
  assign cmp_rd    = '0;
`endif

  assign status        = {28'b0, timer_irq, ovf_q, full, empty};
  assign console_valid = !empty;
  assign console_data  = empty ? 8'h00 : fifo[rd_q];
  assign rdata = !ren          ? '0 :
                 ram_sel       ? mem[addr] :
                 addr == A_ST  ? status :
                 addr == A_CY  ? cyc_rd :
                 addr == A_CMP ? cmp_rd : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
  logic        clk = 1'b0, rst = 1'b1, wen = 1'b0, ren = 1'b0, console_ready = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic        console_valid, timer_irq;
  logic [7:0]  console_data;
  int checks = 0, failures = 0;

  localparam logic [7:0] TX = 8'hF0, ST = 8'hF1, CY = 8'hF2, CMP = 8'hF3;

  dmem_responder dut (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren), .addr(addr), .wdata(wdata),
    .rdata(rdata), .console_valid(console_valid), .console_data(console_data),
    .console_ready(console_ready), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    wen = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 wen = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    addr = a; ren = 1'b1;
    #1 chk(tag, rdata, exp);
    ren = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 32'(console_valid), 0);
    chk("rst_data", 32'(console_data), 0);
    chk("rst_irq", 32'(timer_irq), 0);
    chk("rst_rdata", rdata, 0);
    rd("rst_status", ST, 32'h1);

    wr(8'd5, 32'hDEADBEEF);
    rd("ram_rd", 8'd5, 32'hDEADBEEF);
    #1 chk("ram_ren0", rdata, 0);
    @(negedge clk);
    wen = 1'b1; ren = 1'b1; addr = 8'd5; wdata = 32'h12345678;
    #1 chk("ram_rw_old", rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1 wen = 1'b0;
    chk("ram_rw_new", rdata, 32'h12345678);
    ren = 1'b0;
    rd("ram_other", 8'd6, 32'h0);

    for (int i = 0; i < 8; i++) wr(TX, 32'h41 + i);
    rd("fifo_full", ST, 32'h2);
    chk("fifo_head", 32'(console_data), 32'h41);
    wr(TX, 32'h50);
    rd("fifo_ovf", ST, 32'h6);
    chk("fifo_head_stable", 32'(console_data), 32'h41);

    wr(ST, 32'h4);
    rd("ovf_clear", ST, 32'h2);

    @(negedge clk);
    wen = 1'b1; addr = TX; wdata = 32'h49; console_ready = 1'b1;
    @(posedge clk);
    #1 wen = 1'b0; console_ready = 1'b0;
    rd("pushpop_status", ST, 32'h2);
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(console_valid), 1);
      chk("drain_data", 32'(console_data), 32'h42 + i);
      console_ready = 1'b1;
      tick();
      console_ready = 1'b0;
    end
    chk("drained_valid", 32'(console_valid), 0);
    rd("drained_status", ST, 32'h1);

    rd("unmapped_rd", 8'hF6, 32'h0);
    wr(8'hF6, 32'h123);
    rd("unmapped_wr", 8'hF6, 32'h0);
    rd("tx_reads0", TX, 32'h0);

`ifdef DMEM_RESP_TIMER_EN
    rd("cmp_reset", CMP, 32'hFFFFFFFF);
    wr(CMP, 32'd10);
    wr(CY, 32'd5);
    rd("cyc_written", CY, 32'd5);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("irq_early", 32'(timer_irq), 0);
    end
    tick();
    chk("irq_set", 32'(timer_irq), 1);
    repeat (3) tick();
    chk("irq_sticky", 32'(timer_irq), 1);
    rd("status_irq", ST, 32'h9);
    wr(ST, 32'h8);
    chk("irq_clear", 32'(timer_irq), 0);
    rd("cmp_rd", CMP, 32'd10);
    wr(CY, 32'hFFFFFFFF);
    rd("cyc_max", CY, 32'hFFFFFFFF);
    tick();
    rd("cyc_wrap", CY, 32'h0);
`else
    wr(CY, 32'd5);
    rd("cyc_absent", CY, 32'h0);
    wr(CMP, 32'd10);
    rd("cmp_absent", CMP, 32'h0);
    wr(ST, 32'h8);
    chk("irq_absent", 32'(timer_irq), 0);
`endif

    for (int i = 0; i < 3; i++) wr(TX, 32'h61 + i);
    chk("pre_rst_valid", 32'(console_valid), 1);
    #2 rst = 1'b1;
    #1 chk("async_valid", 32'(console_valid), 0);
    chk("async_data", 32'(console_data), 0);
    chk("async_irq", 32'(timer_irq), 0);
    rd("async_status", ST, 32'h1);
    tick();
    #1 rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(console_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
